// File: rtl/canny_pkg.sv
// Shared types for the edge-detector result path.
// Pixel bundle and writer FSM states.
package canny_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DUMP,
    DONE
  } writer_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pixel_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO of detector result pixels.
// Head is read combinationally; no fall-through.
module result_fifo
  import canny_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  pixel_t wr_px,
  output pixel_t rd_px,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  pixel_t        mem [DEPTH];

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_px = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_px;
  end

endmodule

// File: rtl/edge_frame_writer.sv
// Buffers detector results and drains them into the write SRAM.
// Tracks frame completion, address order and requests a dump.
module edge_frame_writer #(
  parameter int ADDR_W       = canny_pkg::ADDR_W,
  parameter int DATA_W       = canny_pkg::DATA_W,
  parameter int FIFO_DEPTH   = 8,
  parameter int FRAME_PIXELS = 250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              det_we,
  input  logic [ADDR_W-1:0] det_addr,
  input  logic [DATA_W-1:0] det_data,
  input  logic              sram_ready,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data,
  output logic              mem_dump,
  input  logic              dump_ack,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic              addr_error,
  output logic [ADDR_W-1:0] pixel_count
);
  import canny_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_PIX =
    ADDR_W'(FRAME_PIXELS - 1);

  writer_state_t     state;
  writer_state_t     state_nx;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              clear;
  logic [ADDR_W-1:0] exp_addr;
  pixel_t            wr_px;
  pixel_t            head;

  assign pop   = !empty && sram_ready;
  assign push  = (state == RUN) && det_we && (!full || pop);
  assign clear = start && (state == IDLE || state == DONE);
  assign wr_px = '{addr: det_addr, data: det_data};

  assign busy       = (state == RUN) || (state == DRAIN) ||
                      (state == DUMP);
  assign frame_done = (state == DONE);

  result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wr_px (wr_px),
    .rd_px (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (push && pixel_count == LAST_PIX)
                 state_nx = DRAIN;
      DRAIN:   if (empty && !sram_we) state_nx = DUMP;
      DUMP:    if (dump_ack) state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_dump    <= 1'b0;
      pixel_count <= '0;
      exp_addr    <= '0;
      overflow    <= 1'b0;
      addr_error  <= 1'b0;
    end else begin
      mem_dump <= (state_nx == DUMP) && (state != DUMP);
      if (clear) begin
        pixel_count <= '0;
        exp_addr    <= '0;
        overflow    <= 1'b0;
        addr_error  <= 1'b0;
      end else begin
        if (push) begin
          pixel_count <= pixel_count + ADDR_W'(1);
          exp_addr    <= exp_addr + ADDR_W'(1);
          if (det_addr != exp_addr) addr_error <= 1'b1;
        end
        if (state == RUN && det_we && !push)
          overflow <= 1'b1;
        // Samples past the end of the frame are a sequencing fault.
        if (state == DRAIN && det_we)
          addr_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_we   <= 1'b0;
      sram_addr <= '0;
      sram_data <= '0;
    end else begin
      sram_we <= pop;
      if (pop) begin
        sram_addr <= head.addr;
        sram_data <= head.data;
      end
    end
  end

endmodule

// File: tb/tb_edge_frame_writer.sv
// Self-checking bench for edge_frame_writer.
// Scoreboard model plus directed vectors and random traffic.
module tb_edge_frame_writer;
  import canny_pkg::*;

  localparam int DEPTH = 4;
  localparam int FRAME = 16;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;
  localparam int S_DUMP = 3, S_DONE = 4;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic        det_we = 0;
  logic [17:0] det_addr = '0;
  logic [7:0]  det_data = '0;
  logic        sram_ready = 0;
  logic        dump_ack = 0;
  logic        sram_we;
  logic [17:0] sram_addr;
  logic [7:0]  sram_data;
  logic        mem_dump;
  logic        busy;
  logic        frame_done;
  logic        overflow;
  logic        addr_error;
  logic [17:0] pixel_count;

  edge_frame_writer #(
    .ADDR_W       (18),
    .DATA_W       (8),
    .FIFO_DEPTH   (DEPTH),
    .FRAME_PIXELS (FRAME)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .det_we      (det_we),
    .det_addr    (det_addr),
    .det_data    (det_data),
    .sram_ready  (sram_ready),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_data   (sram_data),
    .mem_dump    (mem_dump),
    .dump_ack    (dump_ack),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .addr_error  (addr_error),
    .pixel_count (pixel_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc = 0;

  // Reference model state
  int          m_st;
  pixel_t      mq[$];
  logic        m_we;
  logic [17:0] m_addr;
  logic [7:0]  m_data;
  logic        m_dump;
  int          m_cnt;
  int          m_exp;
  logic        m_ovf;
  logic        m_aerr;

  // Observed SRAM writes
  logic [17:0] wr_a[$];
  logic [7:0]  wr_d[$];
  int          wr_c[$];
  int          push_c[FRAME];

  typedef struct {
    logic        st;
    logic        we;
    logic [17:0] a;
    logic        rdy;
    logic        e_we;
    logic [17:0] e_a;
    logic [7:0]  e_d;
    logic        e_ovf;
    int          e_cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE;
    mq.delete();
    m_we = 0;
    m_addr = '0;
    m_data = '0;
    m_dump = 0;
    m_cnt = 0;
    m_exp = 0;
    m_ovf = 0;
    m_aerr = 0;
  endtask

  task automatic model_step();
    bit     pop;
    bit     acc;
    bit     fl;
    int     nst;
    pixel_t h;
    fl  = (mq.size() == DEPTH);
    pop = (mq.size() != 0) && sram_ready;
    acc = (m_st == S_RUN) && det_we && (!fl || pop);
    nst = m_st;
    case (m_st)
      S_IDLE:  if (start) nst = S_RUN;
      S_RUN:   if (acc && m_cnt + 1 == FRAME) nst = S_DRAIN;
      S_DRAIN: if (mq.size() == 0 && !m_we) nst = S_DUMP;
      S_DUMP:  if (dump_ack) nst = S_DONE;
      S_DONE:  if (start) nst = S_RUN;
      default: nst = S_IDLE;
    endcase
    if (pop) begin
      h = mq.pop_front();
      m_we = 1;
      m_addr = h.addr;
      m_data = h.data;
    end else begin
      m_we = 0;
    end
    if (acc) mq.push_back('{addr: det_addr, data: det_data});
    m_dump = (nst == S_DUMP) && (m_st != S_DUMP);
    if (start && (m_st == S_IDLE || m_st == S_DONE)) begin
      m_cnt = 0;
      m_exp = 0;
      m_ovf = 0;
      m_aerr = 0;
    end else begin
      if (acc) begin
        if (int'(det_addr) != m_exp) m_aerr = 1;
        m_cnt++;
        m_exp++;
      end
      if (m_st == S_RUN && det_we && !acc) m_ovf = 1;
      if (m_st == S_DRAIN && det_we) m_aerr = 1;
    end
    m_st = nst;
  endtask

  task automatic compare_all();
    bit ok;
    bit e_busy;
    bit e_done;
    e_busy = (m_st == S_RUN) || (m_st == S_DRAIN) ||
             (m_st == S_DUMP);
    e_done = (m_st == S_DONE);
    ok = (sram_we == m_we) && (sram_addr == m_addr) &&
         (sram_data == m_data) && (mem_dump == m_dump) &&
         (busy == e_busy) && (frame_done == e_done) &&
         (overflow == m_ovf) && (addr_error == m_aerr) &&
         (int'(pixel_count) == m_cnt);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display({"FAIL model cycle %0d: got we=%b a=%0d d=%0d",
                " dump=%b busy=%b done=%b ovf=%b aerr=%b cnt=%0d;",
                " want we=%b a=%0d d=%0d dump=%b busy=%b done=%b",
                " ovf=%b aerr=%b cnt=%0d"},
               ncyc, sram_we, sram_addr, sram_data, mem_dump,
               busy, frame_done, overflow, addr_error,
               pixel_count, m_we, m_addr, m_data, m_dump,
               e_busy, e_done, m_ovf, m_aerr, m_cnt);
    end
    if (sram_we) begin
      wr_a.push_back(sram_addr);
      wr_d.push_back(sram_data);
      wr_c.push_back(ncyc);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    ncyc++;
    compare_all();
  endtask

  task automatic clear_log();
    wr_a.delete();
    wr_d.delete();
    wr_c.delete();
  endtask

  task automatic check_zero(string nm);
    chk({nm, ".we"}, int'(sram_we), 0);
    chk({nm, ".addr"}, int'(sram_addr), 0);
    chk({nm, ".data"}, int'(sram_data), 0);
    chk({nm, ".dump"}, int'(mem_dump), 0);
    chk({nm, ".busy"}, int'(busy), 0);
    chk({nm, ".done"}, int'(frame_done), 0);
    chk({nm, ".ovf"}, int'(overflow), 0);
    chk({nm, ".aerr"}, int'(addr_error), 0);
    chk({nm, ".cnt"}, int'(pixel_count), 0);
  endtask

  task automatic do_reset(string nm);
    rst = 1;
    #2;
    check_zero(nm);
    @(posedge clk);
    #1;
    rst = 0;
    start = 0;
    det_we = 0;
    sram_ready = 0;
    dump_ack = 0;
    model_reset();
  endtask

  task automatic push(int a, int d, bit rdy);
    if (a < FRAME) push_c[a] = ncyc;
    det_we = 1;
    det_addr = 18'(a);
    det_data = 8'(d);
    sram_ready = rdy;
    cycle();
    det_we = 0;
  endtask

  task automatic do_start();
    start = 1;
    cycle();
    start = 0;
    clear_log();
  endtask

  task automatic wait_dump(string nm, output int pulses);
    bit seen;
    seen = 0;
    pulses = 0;
    det_we = 0;
    sram_ready = 1;
    for (int k = 0; k < 60 && !seen; k++) begin
      cycle();
      if (mem_dump) begin
        seen = 1;
        pulses++;
      end
    end
    if (!seen) chk({nm, ".dump_timeout"}, 0, 1);
    dump_ack = 1;
    cycle();
    dump_ack = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (mem_dump) pulses++;
    end
  endtask

  task automatic clean_frame(string nm);
    int p;
    do_start();
    for (int i = 0; i < FRAME; i++) push(i, i * 3, 1);
    wait_dump(nm, p);
    chk({nm, ".dumps"}, p, 1);
    chk({nm, ".done"}, int'(frame_done), 1);
    chk({nm, ".ovf"}, int'(overflow), 0);
    chk({nm, ".aerr"}, int'(addr_error), 0);
    chk({nm, ".cnt"}, int'(pixel_count), FRAME);
    chk({nm, ".nwr"}, wr_a.size(), FRAME);
    for (int i = 0; i < FRAME && i < wr_a.size(); i++) begin
      chk($sformatf("%s.wa%0d", nm, i), int'(wr_a[i]), i);
      chk($sformatf("%s.wd%0d", nm, i), int'(wr_d[i]),
          (i * 3) & 8'hff);
      chk($sformatf("%s.lat%0d", nm, i),
          wr_c[i] - push_c[i], 2);
    end
  endtask

  function automatic vec_t mk(bit st, bit we, int a, bit rdy,
                              bit e_we, int e_a, bit e_ovf,
                              int e_cnt);
    vec_t v;
    v.st = st;
    v.we = we;
    v.a = 18'(a);
    v.rdy = rdy;
    v.e_we = e_we;
    v.e_a = 18'(e_a);
    v.e_d = 8'(e_a * 3);
    v.e_ovf = e_ovf;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    int p;
    model_reset();
    #3;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 0;

    clean_frame("clean");

    // 17th sample after a full frame
    do_start();
    for (int i = 0; i < FRAME; i++) push(i, i, 1);
    push(FRAME, 0, 1);
    chk("extra.aerr", int'(addr_error), 1);
    chk("extra.cnt", int'(pixel_count), FRAME);
    chk("extra.ovf", int'(overflow), 0);
    wait_dump("extra", p);

    // Out-of-order address still written
    do_start();
    chk("seq.cleared", int'(addr_error), 0);
    push(0, 1, 1);
    push(1, 2, 1);
    push(2, 3, 1);
    chk("seq.aerr_before", int'(addr_error), 0);
    push(7, 4, 1);
    chk("seq.aerr_after", int'(addr_error), 1);
    for (int i = 4; i < FRAME; i++) push(i, i, 1);
    wait_dump("seq", p);
    chk("seq.nwr", wr_a.size(), FRAME);
    if (wr_a.size() > 3) chk("seq.wa3", int'(wr_a[3]), 7);

    // Reset mid-frame
    do_start();
    for (int i = 0; i < 5; i++) push(i, i, 0);
    do_reset("midrst");
    for (int k = 0; k < 3; k++) begin
      sram_ready = 1;
      cycle();
    end
    chk("midrst.nodump", int'(mem_dump), 0);
    clean_frame("after_rst");

    // Full FIFO with same-cycle pop, then backpressure drops
    do_reset("tbl_rst");
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 1, 1, 0, 0, 0, 0, 2);
    tbl[3]  = mk(0, 1, 2, 0, 0, 0, 0, 3);
    tbl[4]  = mk(0, 1, 3, 0, 0, 0, 0, 4);
    tbl[5]  = mk(0, 1, 4, 1, 1, 0, 0, 5);
    tbl[6]  = mk(0, 1, 5, 1, 1, 1, 0, 6);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 6);
    tbl[8]  = mk(0, 1, 6, 0, 0, 1, 1, 6);
    tbl[9]  = mk(0, 1, 7, 0, 0, 1, 1, 6);
    tbl[10] = mk(0, 0, 0, 1, 1, 2, 1, 6);
    tbl[11] = mk(0, 0, 0, 1, 1, 3, 1, 6);
    tbl[12] = mk(0, 0, 0, 1, 1, 4, 1, 6);
    tbl[13] = mk(0, 0, 0, 1, 1, 5, 1, 6);
    tbl[14] = mk(0, 0, 0, 1, 0, 5, 1, 6);
    for (int i = 0; i < 15; i++) begin
      start = tbl[i].st;
      det_we = tbl[i].we;
      det_addr = tbl[i].a;
      det_data = 8'(tbl[i].a * 3);
      sram_ready = tbl[i].rdy;
      cycle();
      chk($sformatf("tbl%0d.we", i), int'(sram_we),
          int'(tbl[i].e_we));
      chk($sformatf("tbl%0d.addr", i), int'(sram_addr),
          int'(tbl[i].e_a));
      chk($sformatf("tbl%0d.data", i), int'(sram_data),
          int'(tbl[i].e_d));
      chk($sformatf("tbl%0d.ovf", i), int'(overflow),
          int'(tbl[i].e_ovf));
      chk($sformatf("tbl%0d.cnt", i), int'(pixel_count),
          tbl[i].e_cnt);
      chk($sformatf("tbl%0d.aerr", i), int'(addr_error), 0);
      chk($sformatf("tbl%0d.busy", i), int'(busy), 1);
    end
    start = 0;
    det_we = 0;

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset("rnd_rst");
      end else begin
        start = ($urandom_range(0, 15) == 0);
        det_we = ($urandom_range(0, 9) < 7);
        det_addr = ($urandom_range(0, 19) == 0) ?
                   18'($urandom) : 18'(m_exp);
        det_data = 8'($urandom);
        sram_ready = ($urandom_range(0, 3) != 0);
        dump_ack = ($urandom_range(0, 2) == 0);
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
